// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the sequential word popcount block:
//   state_e : controller states (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the count and chunk-index registers
// -----------------------------------------------------------------------------
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Smallest r such that 2**r >= value. Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/popcount8.sv
// -----------------------------------------------------------------------------
// popcount8
// Combinational population count of one byte.
// Ports:
//   data_i  [7:0] : byte to count
//   count_o [3:0] : number of set bits in data_i (0..8)
// -----------------------------------------------------------------------------
module popcount8 (
   input  logic [7:0] data_i,
   output logic [3:0] count_o
);

   always_comb begin
      count_o = 4'd0;
      for (int i = 0; i < 8; i++) begin
         count_o = count_o + {3'd0, data_i[i]};
      end
   end

endmodule

// File: rtl/popcount_word_seq.sv
// -----------------------------------------------------------------------------
// popcount_word_seq
// Multi-cycle population counter for WIDTH-bit words. One shared popcount8
// unit processes one byte per cycle, LSB byte first, accumulating the partial
// counts. Both sides use valid/ready handshakes.
//
// Handshake rule (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both high. The sender holds valid and data stable until
// the transfer; ready never depends on valid.
//
// Ports:
//   CLK         : clock, all state updates on the rising edge
//   ASYNCRESETN : asynchronous active-low reset
//   I [WIDTH]   : input word, sampled only on an input handshake
//   I_VALID     : producer has a word
//   I_READY     : block can accept a word (high only in IDLE)
//   O [CW]      : population count of the last accepted word
//   O_VALID     : O holds a completed result (high only in DONE)
//   O_READY     : consumer takes the result
//   BUSY        : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module popcount_word_seq
   import popcount_pkg::*;
#(
   parameter  int WIDTH  = 32,
   localparam int NCHUNK = WIDTH / 8,
   localparam int CW     = clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [CW-1:0]    O,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic             BUSY
);

   // A single-chunk word still needs a 1-bit index register.
   localparam int IW = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if (((WIDTH % 8) != 0) || (WIDTH < 8)) begin : g_width_check
      $error("popcount_word_seq: WIDTH must be a multiple of 8 and >= 8");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]    idx_q,   idx_d;
   logic [CW-1:0]    acc_q,   acc_d;
   logic [CW-1:0]    o_q,     o_d;
   logic [3:0]       chunk_cnt;
   logic [CW-1:0]    sum;

   popcount8 u_popcount8 (
      .data_i  (shift_q[7:0]),
      .count_o (chunk_cnt)
   );

   // Max total is WIDTH < 2**CW, so this add can never wrap.
   assign sum = acc_q + CW'(chunk_cnt);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      o_d     = o_q;
      case (state_q)
         IDLE: begin
            if (I_VALID) begin
               shift_d = I;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = sum;
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IW'(1);
            // The last chunk's sum goes straight to O on the same edge.
            if (idx_q == LAST_IDX) begin
               o_d     = sum;
               state_d = DONE;
            end
         end
         DONE: begin
            if (O_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         o_q     <= o_d;
      end
   end

   assign I_READY = (state_q == IDLE);
   assign O_VALID = (state_q == DONE);
   assign BUSY    = (state_q != IDLE);
   assign O       = o_q;

endmodule

// File: doc/popcount_word_seq.md
Name: popcount_word_seq

Overview:
- Multi-cycle population counter for WIDTH-bit words.
- Time-shares one combinational 8-bit popcount unit: one byte per cycle, LSB byte first, accumulating the partial counts.
- Sits between an upstream producer and a downstream consumer; both sides use valid/ready handshakes.
- Trades throughput for area compared with a fully unrolled wide counter.

Parameters:
- WIDTH, 32, input word width; must be a multiple of 8 and >= 8 (elaboration error otherwise).
- NCHUNK, WIDTH/8, number of byte chunks; derived, not overridable.
- CW, clog2(WIDTH+1), count width; derived (6 for WIDTH=32).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- I  in  WIDTH  input word; sampled only on an input handshake.
- I_VALID  in  1  producer has a word.
- I_READY  out  1  block can accept a word.
- O  out  CW  population count of the last accepted word.
- O_VALID  out  1  O holds a completed result.
- O_READY  in  1  consumer takes the result.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (ASYNCRESETN low, any time, any state): state=IDLE, shift register=0, chunk index=0, acc=0, O=0, O_VALID=0, BUSY=0, I_READY=1 once reset is released. An in-flight word is discarded and no partial result is emitted.
- I_READY = (state==IDLE), combinational from state only; it does not depend on I_VALID.
- IDLE:
  - On I_VALID & I_READY at edge t: latch I into the shift register, acc=0, idx=0, go to RUN.
  - I_VALID low: stay in IDLE.
- RUN, each cycle:
  - acc <= acc + popcount8(shift[7:0]), with the popcount zero-extended to CW bits.
  - shift <= shift >> 8; idx <= idx+1.
  - When idx == NCHUNK-1, the same edge moves to DONE and writes the final sum into O.
- Latency: handshake at edge t → O_VALID high after edge t+NCHUNK (t+4 for WIDTH=32).
- DONE:
  - O_VALID=1 and O held stable until O_VALID & O_READY.
  - On that edge, go to IDLE with O_VALID=0. O keeps its last value; it is don't-care while O_VALID=0.
  - No acceptance in DONE or RUN. Minimum initiation interval is NCHUNK+2 cycles with O_READY tied high.
- I_VALID asserted during RUN or DONE has no effect; the producer holds it until I_READY.
- O_READY asserted outside DONE is ignored.
- Arithmetic:
  - acc never overflows, since max = WIDTH < 2^CW.
  - All-ones input gives WIDTH; all-zeros gives 0.
  - No saturation or wrap logic is required.
- X-safety: the I contents are irrelevant outside a handshake.

Decomposition:
- Shared package popcount_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - clog2 helper used to derive CW.
- Sub-module: the existing combinational popcount8 unit (8-bit in, 4-bit out), instantiated once and fed shift[7:0]. It is reused, not re-implemented.
- Chunk counter, accumulator and FSM live in the top module.
- Expected size: about 150 RTL lines.

Test Plan:
- Single word:
  - WIDTH=32, I=32'h0000_0000 → O=0; O_VALID rises exactly 4 cycles after the handshake edge.
  - I=32'hFFFF_FFFF → O=32.
  - I=32'h0102_0408 → O=4.
  - I=32'h8000_0001 → O=2 (checks first and last chunk).
- Back-pressure: I=32'h0F0F_0F0F, O_READY held low 5 cycles after O_VALID → O stays 16 and O_VALID stays 1; I_READY stays 0; a second I_VALID with I=32'hFFFF_FFFF is not accepted until after the O handshake, then yields O=32.
- Streaming: O_READY tied high, 10 random words back-to-back → results match a reference model in order; handshakes spaced exactly 6 cycles apart.
- Reset mid-operation: assert ASYNCRESETN low between clock edges during the 2nd RUN cycle → O_VALID=0, BUSY=0, O=0 immediately (asynchronously); after release, I_READY=1; the next word I=32'h0000_00FF gives O=8 with no residue from the aborted word.
- Parameter sweep: WIDTH=8, I=8'hA5 → O=4 one cycle after handshake. WIDTH=64 all-ones → O=64 (CW=7) after 8 cycles.
